// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: one shared shift/add-subtract datapath, XLEN iterations, then sign fix-up.
// Latency XLEN+2 cycles start->o_valid (divide-by-zero: 1 cycle); stalls the core while working, start ignored unless IDLE.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle multiplier (valid one cycle after start).
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     mcand_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                neg_res_q, neg_rem_q;
    logic [XLEN-1:0]     result_q;

    // Start-cycle decode: which operands are signed, their magnitudes, result signs
    logic            sgn_a, sgn_b, a_neg, b_neg, start_ok, dz;
    logic [XLEN-1:0] abs_a, abs_b, dz_res;

    always_comb begin
        sgn_a    = (i_op == 3'b001) || (i_op == 3'b010) || (i_op == 3'b100) || (i_op == 3'b110);
        sgn_b    = (i_op == 3'b001) || (i_op == 3'b100) || (i_op == 3'b110);
        a_neg    = sgn_a && i_rs1[XLEN-1];
        b_neg    = sgn_b && i_rs2[XLEN-1];
        abs_a    = a_neg ? -i_rs1 : i_rs1;
        abs_b    = b_neg ? -i_rs2 : i_rs2;
        start_ok = (state_q == IDLE) && i_start && !i_flush;
        dz       = i_op[2] && (i_rs2 == '0);
        dz_res   = i_op[1] ? i_rs1 : '1;
    end

    // Restoring divide step: acc = {remainder, dividend/quotient}
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        div_next  = {(div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0]),
                     acc_q[XLEN-2:0], ~div_diff[XLEN]};
    end

`ifndef MULDIV_FAST_MUL_EN
    // Shift-add multiply step: acc = {partial product, remaining multiplier bits}
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
    end
`else
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_prod = abs_a * abs_b;
        if (a_neg ^ b_neg)
            fast_prod = -fast_prod;
        fast_res = (i_op == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        fix_res  = '0;
        if (!op_q[2])
            fix_res = (op_q == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (op_q[1])
            fix_res = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        else
            fix_res = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (dz)
                        state_d = DONE;
`ifdef MULDIV_FAST_MUL_EN
                    else if (!i_op[2])
                        state_d = DONE;
`endif
                    else
                        state_d = CALC;
                end
            end
            CALC: begin
                if (i_flush)
                    state_d = IDLE;
                else if (cnt_q == CNT_W'(XLEN-1))
                    state_d = FIX;
            end
            FIX:     state_d = i_flush ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            op_q      <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        op_q      <= i_op;
                        mcand_q   <= abs_b;
                        acc_q     <= {{XLEN{1'b0}}, abs_a};
                        cnt_q     <= '0;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (dz)
                            result_q <= dz_res;
`ifdef MULDIV_FAST_MUL_EN
                        else if (!i_op[2])
                            result_q <= fast_res;
`endif
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                    acc_q <= div_next;
`else
                    acc_q <= op_q[2] ? div_next : mul_next;
`endif
                end
                FIX: begin
                    if (!i_flush)
                        result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign o_busy   = (state_q != IDLE);
    assign o_stall  = start_ok || (state_q == CALC) || (state_q == FIX);
    assign o_valid  = (state_q == DONE);
    assign o_result = result_q;

endmodule
